// File: rtl/kamacore_seq.sv
// kamacore_seq: multi-cycle fetch/decode/execute/writeback sequencer for the OP and OP-IMM classes.
// Any other encoding parks the core in HALT with the sticky illegal flag set.
module kamacore_seq #(
  parameter int CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic                 imem_req,
  output logic [CPU_WIDTH-1:0] imem_addr,
  input  logic                 imem_ready,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          instr,
  output logic [4:0]           rs1_addr,
  output logic [4:0]           rs2_addr,
  input  logic [CPU_WIDTH-1:0] rs1_data,
  input  logic [CPU_WIDTH-1:0] rs2_data,
  output logic [CPU_WIDTH-1:0] src1,
  output logic [CPU_WIDTH-1:0] src2,
  input  logic [CPU_WIDTH-1:0] alu_result,
  output logic                 rd_we,
  output logic [4:0]           rd_addr,
  output logic [CPU_WIDTH-1:0] rd_wdata,
  output logic [CPU_WIDTH-1:0] pc,
  output logic                 retired,
  output logic [CPU_WIDTH-1:0] instret,
  output logic                 halted,
  output logic                 illegal
);
  localparam int W = CPU_WIDTH;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] pc_q, pc_d, src1_q, src1_d, src2_q, src2_d, res_q, res_d, instret_q, instret_d;
  logic [31:0] instr_q, instr_d;
  logic req_hold_q, req_hold_d, illegal_q, illegal_d, fire, legal;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];
  // Shift-immediate forms encode funct7 in the immediate, so only those funct3 values constrain it
  assign legal = opcode == 7'b0010011
    ? (funct3 == 3'b001 ? funct7 == 7'b0000000
      : funct3 == 3'b101 ? (funct7 == 7'b0000000 || funct7 == 7'b0100000) : 1'b1)
    : opcode == 7'b0110011
    ? (funct7 == 7'b0000000 || (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
    : 1'b0;
  // A raised request is held until accepted, even if run drops
  assign imem_req = !rst && state_q == FETCH && (run || req_hold_q);
  assign fire = imem_req && imem_ready;
  assign imem_addr = pc_q;
  assign instr = instr_q;
  assign rs1_addr = instr_q[19:15];
  assign rs2_addr = instr_q[24:20];
  assign rd_addr = instr_q[11:7];
  assign src1 = src1_q;
  assign src2 = src2_q;
  assign rd_wdata = res_q;
  assign pc = pc_q;
  assign instret = instret_q;
  assign retired = state_q == WRITEBACK;
  assign rd_we = state_q == WRITEBACK && instr_q[11:7] != 5'd0;
  assign halted = state_q == HALT;
  assign illegal = illegal_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    src1_d = src1_q;
    src2_d = src2_q;
    res_d = res_q;
    instret_d = instret_q;
    illegal_d = illegal_q;
    req_hold_d = imem_req && !imem_ready;
    case (state_q)
      FETCH: begin
        instr_d = fire ? imem_rdata : instr_q;
        state_d = fire ? DECODE : FETCH;
      end
      DECODE: begin
        src1_d = rs1_data;
        src2_d = rs2_data;
        illegal_d = illegal_q || !legal;
        state_d = legal ? EXECUTE : HALT;
      end
      EXECUTE: begin
        res_d = alu_result;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        pc_d = pc_q + W'(4);
        instret_d = instret_q + W'(1);
        state_d = FETCH;
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      instr_q <= 32'h0000_0013;
      src1_q <= '0;
      src2_q <= '0;
      res_q <= '0;
      instret_q <= '0;
      req_hold_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
      res_q <= res_d;
      instret_q <= instret_d;
      req_hold_q <= req_hold_d;
      illegal_q <= illegal_d;
    end
  end
endmodule

// File: tb/tb_kamacore_seq.sv
// tb_kamacore_seq: scoreboard bench for kamacore_seq; expected writebacks are queued at issue
// and popped when the sequencer retires.
module tb_kamacore_seq;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, imem_ready = 1'b1;
  logic imem_req, rd_we, retired, halted, illegal;
  logic [31:0] imem_addr, imem_rdata, instr, rs1_data, rs2_data, src1, src2, alu_result, rd_wdata, pc, instret;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic [31:0] mem_instr = 32'h13, r1v = '0, r2v = '0;
  logic w_req, w_we, w_ret, w_halted, w_illegal;
  logic [31:0] w_addr, w_instr, w_src1, w_src2, w_wdata, w_pc, w_instret;
  logic [4:0] w_rs1, w_rs2, w_rd;
  int checks = 0, failures = 0;
  typedef struct packed {logic we; logic [4:0] rd; logic [31:0] wd;} exp_t;
  exp_t sbq[$];
  logic [31:0] exp_pc = '0, exp_ret = '0;

  always #5 clk = ~clk;
  assign imem_rdata = mem_instr;
  assign rs1_data = r1v;
  assign rs2_data = r2v;
  // Tiny ALU stand-in: OP-IMM adds the sign-extended immediate, OP adds the operands
  assign alu_result = instr[6:0] == 7'h13 ? src1 + {{20{instr[31]}}, instr[31:20]} : src1 + src2;

  kamacore_seq dut (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data), .src1(src1), .src2(src2),
    .alu_result(alu_result), .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata), .pc(pc),
    .retired(retired), .instret(instret), .halted(halted), .illegal(illegal)
  );

  kamacore_seq #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .run(1'b1), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rdata(32'h0050_0093), .instr(w_instr), .rs1_addr(w_rs1),
    .rs2_addr(w_rs2), .rs1_data(32'd0), .rs2_data(32'd0), .src1(w_src1), .src2(w_src2),
    .alu_result(32'd5), .rd_we(w_we), .rd_addr(w_rd), .rd_wdata(w_wdata), .pc(w_pc),
    .retired(w_ret), .instret(w_instret), .halted(w_halted), .illegal(w_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rd_we && !retired) chk("we_stray", 32'(rd_we), 32'd0);
    if (!rst && retired) begin
      if (sbq.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_we", 32'(rd_we), 32'(e.we));
        chk("sb_rd", 32'(rd_addr), 32'(e.rd));
        chk("sb_wd", rd_wdata, e.wd);
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic we, input logic [4:0] rd, input logic [31:0] wd, input string tag);
    int n;
    @(posedge clk); #1;
    mem_instr = ins; r1v = a; r2v = b;
    sbq.push_back(exp_t'{we, rd, wd});
    run = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (imem_req && imem_ready) break;
    end
    chk({tag, "_addr"}, imem_addr, exp_pc);
    @(posedge clk); #1 run = 1'b0;
    for (n = 1; n < 20; n++) begin
      @(negedge clk);
      if (retired) break;
    end
    chk({tag, "_lat"}, 32'(n), 32'd3);
    @(negedge clk);
    exp_pc += 4;
    exp_ret += 1;
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_ret"}, instret, exp_ret);
    chk({tag, "_idle"}, 32'(imem_req), 32'd0);
  endtask

  task automatic reset_core();
    rst = 1'b1;
    sbq.delete();
    exp_pc = '0;
    exp_ret = '0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bad [3];
    int n;
    bad[0] = 32'h0000_2083;
    bad[1] = 32'h4020_F0B3;
    bad[2] = 32'h4010_9093;
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_we", 32'(rd_we), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_src", src1 | src2 | rd_wdata | instret, 32'd0);
    chk("rst_flags", {30'd0, halted, illegal}, 32'd0);
    @(posedge clk); #1 rst = 1'b0; run = 1'b0;
    @(negedge clk);
    chk("idle_run0", 32'(imem_req), 32'd0);
    issue(32'h0050_0093, 0, 0, 1'b1, 5'd1, 32'd5, "basic");
    chk("wrap_pc", w_pc, 32'd0);
    chk("wrap_ret", w_instret, 32'd1);
    issue(32'h0030_0113, 0, 0, 1'b1, 5'd2, 32'd3, "addi2");
    issue(32'h0020_8033, 7, 9, 1'b0, 5'd0, 32'd16, "x0");
    chk("x0_src1", src1, 32'd7);
    chk("x0_src2", src2, 32'd9);
    issue(32'h4020_8233, 7, 9, 1'b1, 5'd4, 32'd16, "sub");
    issue(32'h4010_D193, 7, 0, 1'b1, 5'd3, 32'd1032, "srai");
    // Memory wait: three cycles without ready, run dropped during the second
    @(posedge clk); #1;
    mem_instr = 32'h00A0_0293; r1v = '0;
    sbq.push_back(exp_t'{1'b1, 5'd5, 32'd10});
    imem_ready = 1'b0; run = 1'b1;
    @(negedge clk);
    chk("wait1_req", 32'(imem_req), 32'd1);
    chk("wait1_addr", imem_addr, exp_pc);
    @(posedge clk); #1 run = 1'b0;
    @(negedge clk);
    chk("wait2_req", 32'(imem_req), 32'd1);
    chk("wait2_addr", imem_addr, exp_pc);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait3_req", 32'(imem_req), 32'd1);
    @(posedge clk); #1 imem_ready = 1'b1;
    for (n = 1; n < 20; n++) begin
      @(negedge clk);
      if (retired) break;
    end
    chk("wait_lat", 32'(n), 32'd4);
    exp_pc += 4;
    exp_ret += 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_norun", 32'(imem_req), 32'd0);
    end
    chk("wait_pc", pc, exp_pc);
    chk("wait_ret", instret, exp_ret);
    // instret adder wrap with the counter held at all ones
    @(posedge clk); #1;
    mem_instr = 32'h0050_0093;
    sbq.push_back(exp_t'{1'b1, 5'd1, 32'd5});
    run = 1'b1;
    @(negedge clk);
    chk("iw_req", 32'(imem_req), 32'd1);
    @(posedge clk); #1 run = 1'b0;
    force dut.instret_q = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("iw_retired", 32'(retired), 32'd1);
    chk("iw_next", dut.instret_d, 32'd0);
    @(posedge clk); #1 release dut.instret_q;
    // Asynchronous reset in the middle of EXECUTE
    @(posedge clk); #1;
    mem_instr = 32'h0070_0093;
    run = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("ar_req", 32'(imem_req), 32'd0);
    chk("ar_we", 32'(rd_we), 32'd0);
    chk("ar_pc", pc, 32'd0);
    chk("ar_instr", instr, 32'h13);
    chk("ar_ret", instret, 32'd0);
    sbq.delete();
    exp_pc = '0;
    exp_ret = '0;
    @(posedge clk); #1 rst = 1'b0;
    sbq.push_back(exp_t'{1'b1, 5'd1, 32'd7});
    @(negedge clk);
    chk("ar_resume_req", 32'(imem_req), 32'd1);
    chk("ar_resume_addr", imem_addr, 32'd0);
    @(posedge clk); #1 run = 1'b0;
    for (n = 1; n < 20; n++) begin
      @(negedge clk);
      if (retired) break;
    end
    chk("ar_lat", 32'(n), 32'd3);
    @(negedge clk);
    chk("ar_pc4", pc, 32'd4);
    // Illegal encodings: load, R-type funct7=0100000/funct3=111, SLLI with nonzero funct7
    foreach (bad[k]) begin
      reset_core();
      mem_instr = bad[k];
      run = 1'b1;
      @(negedge clk);
      chk("ill_fetch", 32'(imem_req && imem_ready), 32'd1);
      @(negedge clk);
      chk("ill_dec_halted", 32'(halted), 32'd0);
      @(negedge clk);
      chk("ill_halted", 32'(halted), 32'd1);
      chk("ill_flag", 32'(illegal), 32'd1);
      chk("ill_pc", pc, 32'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("ill_noreq", 32'(imem_req), 32'd0);
        chk("ill_nowe", 32'(rd_we), 32'd0);
      end
      chk("ill_ret", instret, 32'd0);
    end
    run = 1'b0;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
